// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the icache/dcache memory arbiter.
package cache_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_t;

endpackage

// File: rtl/cache_arb_select.sv
// Tie-break between icache and dcache requests.
// CACHE_ARB_ROUND_ROBIN_EN selects round-robin; otherwise the dcache always wins ties.
module cache_arb_select
  import cache_arb_pkg::*;
(
  input  logic i_pending,
  input  logic d_pending,
  input  req_t last_grant,
  output req_t selected
);

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  always_comb begin
    selected = REQ_D;
    if (i_pending && d_pending) begin
      selected = (last_grant == REQ_D) ? REQ_I : REQ_D;
    end else if (i_pending) begin
      selected = REQ_I;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    selected = REQ_D;
    if (i_pending && !d_pending) begin
      selected = REQ_I;
    end
  end
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates icache line fills and dcache reads/writebacks onto one memory port.
// Define CACHE_ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: dcache priority).
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LINE_W-1:0] wdata_reg, wdata_next;
  logic              read_reg, read_next;
  logic              write_reg, write_next;
  logic              i_pending, d_pending;
  req_t              selected, last_grant_eff;

  assign i_pending = i_read;
  assign d_pending = d_read | d_write;

  cache_arb_select u_select (
    .i_pending  (i_pending),
    .d_pending  (d_pending),
    .last_grant (last_grant_eff),
    .selected   (selected)
  );

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  req_t last_grant_reg, last_grant_next;
  logic granted_reg, granted_next;

  // Until the first grant after reset, present the icache as last winner so a tie goes to the dcache.
  assign last_grant_eff = granted_reg ? last_grant_reg : REQ_I;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_reg <= REQ_D;
      granted_reg    <= 1'b0;
    end else begin
      last_grant_reg <= last_grant_next;
      granted_reg    <= granted_next;
    end
  end

  always_comb begin
    last_grant_next = last_grant_reg;
    granted_next    = granted_reg;
    if (state_reg == IDLE && (i_pending || d_pending)) begin
      last_grant_next = selected;
      granted_next    = 1'b1;
    end
  end
`else
  assign last_grant_eff = REQ_D;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      read_reg  <= read_next;
      write_reg <= write_next;
    end
  end

  // The request is captured on the grant so the memory port never sees requester inputs directly.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    read_next  = read_reg;
    write_next = write_reg;
    case (state_reg)
      IDLE: begin
        if (i_pending || d_pending) begin
          if (selected == REQ_D) begin
            state_next = GRANT_D;
            addr_next  = d_address;
            wdata_next = d_wdata;
            write_next = d_write;
            read_next  = !d_write;
          end else begin
            state_next = GRANT_I;
            addr_next  = i_address;
            wdata_next = '0;
            write_next = 1'b0;
            read_next  = 1'b1;
          end
        end
      end
      GRANT_I, GRANT_D: begin
        if (pmem_resp) begin
          state_next = IDLE;
          read_next  = 1'b0;
          write_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        read_next  = 1'b0;
        write_next = 1'b0;
      end
    endcase
  end

  assign pmem_address = addr_reg;
  assign pmem_wdata   = wdata_reg;
  assign pmem_read    = read_reg;
  assign pmem_write   = write_reg;

  assign i_resp  = (state_reg == GRANT_I) && pmem_resp;
  assign d_resp  = (state_reg == GRANT_D) && pmem_resp;
  assign i_rdata = i_resp ? pmem_rdata : '0;
  assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter with a delayed-response memory model.
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] i_address, d_address;
  logic          i_read, d_read, d_write;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] i_rdata, d_rdata;
  logic          i_resp, d_resp;
  logic [AW-1:0] pmem_address;
  logic          pmem_read, pmem_write;
  logic [LW-1:0] pmem_wdata, pmem_rdata;
  logic          pmem_resp;

  int            mem_delay;
  int            mem_cnt = 0;
  logic          auto_resp = 1'b0;
  logic          stray_resp;
  logic [LW-1:0] rdata_pat;

  int n_checks = 0;
  int n_errors = 0;

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_address    (i_address),
    .i_read       (i_read),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_address    (d_address),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  // Memory answers mem_delay cycles after a request first appears.
  always @(posedge clk) begin
    #1;
    if (pmem_read || pmem_write) begin
      mem_cnt   = mem_cnt + 1;
      auto_resp = (mem_cnt >= mem_delay);
    end else begin
      mem_cnt   = 0;
      auto_resp = 1'b0;
    end
  end

  assign pmem_resp  = auto_resp | stray_resp;
  assign pmem_rdata = rdata_pat;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_resp(input int budget, output int cyc);
    cyc = 0;
    while (!(i_resp || d_resp) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("resp_seen", {255'd0, (i_resp | d_resp)}, 1);
    $display("txn: i_resp=%0b d_resp=%0b rd=%0b wr=%0b addr=%h after %0d cycles",
             i_resp, d_resp, pmem_read, pmem_write, pmem_address, cyc);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  logic [7:0] order;
  int         ngr, i_left, d_left, cyc;

  initial begin
    i_address = '0; d_address = '0; d_wdata = '0;
    stray_resp = 1'b0; mem_delay = 3;
    rdata_pat = {32{8'hA5}};

    // Reset values
    rst = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    repeat (2) step();
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_pmem_addr", pmem_address, 0);
    check("rst_pmem_wdata", pmem_wdata, 0);
    check("rst_resp", {i_resp, d_resp}, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    rst = 1'b1;
    step();

    // Icache-only fill, 3-cycle memory
    i_read = 1'b1; i_address = 32'h0000_1000;
    step();
    check("ic_pmem_read", pmem_read, 1);
    check("ic_pmem_write", pmem_write, 0);
    check("ic_pmem_addr", pmem_address, 32'h1000);
    check("ic_early_resp", i_resp, 0);
    wait_resp(20, cyc);
    check("ic_latency", cyc, 2);
    check("ic_resp", i_resp, 1);
    check("ic_rdata", i_rdata, {32{8'hA5}});
    check("ic_d_idle", {d_resp, d_rdata}, 0);
    i_read = 1'b0;
    step();
    check("ic_resp_once", i_resp, 0);
    check("ic_rdata_zero", i_rdata, 0);
    check("ic_pmem_drop", pmem_read, 0);

    // Simultaneous icache read and dcache write: dcache first
    mem_delay = 2; rdata_pat = {32{8'hC3}};
    i_read = 1'b1; i_address = 32'h100;
    d_write = 1'b1; d_address = 32'h200; d_wdata = {32{8'h5A}};
    step();
    check("sim_pmem_write", pmem_write, 1);
    check("sim_pmem_read", pmem_read, 0);
    check("sim_addr_d", pmem_address, 32'h200);
    check("sim_wdata", pmem_wdata, {32{8'h5A}});
    wait_resp(20, cyc);
    check("sim_d_resp", d_resp, 1);
    check("sim_i_blocked", {i_resp, i_rdata}, 0);
    d_write = 1'b0;
    step();
    check("sim_idle_gap", {pmem_read, pmem_write}, 0);
    step();
    check("sim_i_grant", pmem_read, 1);
    check("sim_addr_i", pmem_address, 32'h100);
    wait_resp(20, cyc);
    check("sim_i_resp", i_resp, 1);
    check("sim_i_rdata", i_rdata, {32{8'hC3}});
    i_read = 1'b0;
    step();

    // d_read and d_write together: write wins
    mem_delay = 1;
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h700; d_wdata = {32{8'h3C}};
    step();
    check("rw_pmem_write", pmem_write, 1);
    check("rw_pmem_read", pmem_read, 0);
    check("rw_wdata", pmem_wdata, {32{8'h3C}});
    wait_resp(20, cyc);
    check("rw_d_resp", d_resp, 1);
    d_read = 1'b0; d_write = 1'b0;
    step();

    // Four back-to-back requests from each side after a fresh reset
    do_reset();
    step();
    mem_delay = 1;
    i_read = 1'b1; i_address = 32'h500;
    d_read = 1'b1; d_address = 32'h600;
    i_left = 4; d_left = 4; order = '0; ngr = 0;
    for (int c = 0; c < 200 && (i_left > 0 || d_left > 0); c++) begin
      step();
      if (d_resp) begin
        order = {order[6:0], 1'b1}; ngr++; d_left--;
        $display("txn: grant D #%0d", ngr);
        if (d_left == 0) d_read = 1'b0;
      end
      if (i_resp) begin
        order = {order[6:0], 1'b0}; ngr++; i_left--;
        $display("txn: grant I #%0d", ngr);
        if (i_left == 0) i_read = 1'b0;
      end
    end
    check("b2b_count", ngr, 8);
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    check("b2b_order", order, 8'b1010_1010);
`else
    check("b2b_order", order, 8'b1111_0000);
`endif
    step();

    // Reset in the middle of an icache grant
    mem_delay = 1000;
    i_read = 1'b1; i_address = 32'h300;
    step();
    check("mr_grant", pmem_read, 1);
    step();
    rst = 1'b0;
    step();
    check("mr_pmem_read", pmem_read, 0);
    check("mr_pmem_addr", pmem_address, 0);
    check("mr_no_resp", i_resp, 0);
    rst = 1'b1; i_read = 1'b0;
    step();
    stray_resp = 1'b1;
    #1;
    check("mr_stray_i", {i_resp, i_rdata}, 0);
    check("mr_stray_d", {d_resp, d_rdata}, 0);
    step();
    check("mr_stray_hold", {i_resp, d_resp, pmem_read}, 0);
    stray_resp = 1'b0;
    step();

    // Dcache drops its read one cycle into the grant
    mem_delay = 4; rdata_pat = {32{8'h96}};
    d_read = 1'b1; d_address = 32'h400;
    step();
    check("dr_grant", pmem_read, 1);
    d_read = 1'b0;
    step();
    check("dr_hold_read", pmem_read, 1);
    check("dr_hold_addr", pmem_address, 32'h400);
    wait_resp(20, cyc);
    check("dr_d_resp", d_resp, 1);
    check("dr_d_rdata", d_rdata, {32{8'h96}});
    step();
    check("dr_done", {pmem_read, d_resp}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, physical address width.
REQ-002 SHALL have parameter LINE_W, default 256, cache line width in bits.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low (rst=0 resets).
REQ-005 SHALL have ports i_address input ADDR_W, i_read input 1: icache line-fill request.
REQ-006 SHALL have ports i_rdata output LINE_W, i_resp output 1: icache response.
REQ-007 SHALL have ports d_address input ADDR_W, d_read input 1, d_write input 1, d_wdata input LINE_W: dcache request and writeback.
REQ-008 SHALL have ports d_rdata output LINE_W, d_resp output 1: dcache response.
REQ-009 SHALL have ports pmem_address output ADDR_W, pmem_read output 1, pmem_write output 1, pmem_wdata output LINE_W: shared memory request.
REQ-010 SHALL have ports pmem_rdata input LINE_W, pmem_resp input 1: shared memory response.

Function
REQ-011 SHALL implement FSM states IDLE, GRANT_I, GRANT_D.
REQ-012 IDLE: no request pending -> stay IDLE; pmem_read=pmem_write=0.
REQ-013 IDLE: request pending -> next state GRANT_I or GRANT_D per selection rule (REQ-020); the selection decision is registered.
REQ-014 Request SHALL be latched on IDLE->GRANT_x: address, read/write, and wdata are captured into registers; pmem_* SHALL be driven from these registers only, never combinationally from requester inputs.
REQ-015 Latency: pmem_read/pmem_write SHALL assert the cycle after the request is first seen in IDLE (one-cycle grant latency).
REQ-016 GRANT_x: pmem_* SHALL be held stable until pmem_resp=1.
REQ-017 On pmem_resp=1 in GRANT_x, x_resp=1 for exactly that cycle, x_rdata=pmem_rdata (combinational pass-through); next state IDLE; pmem_read/pmem_write SHALL deassert the next cycle.
REQ-018 Non-granted requester SHALL see resp=0; i_rdata and d_rdata SHALL be 0 when their resp=0.
REQ-019 A requester keeps its request asserted until its resp; after resp, at least one IDLE cycle SHALL occur before any new grant (no back-to-back re-grant on the stale request).
REQ-020 Selection when both pending: per REQ-027/REQ-028. When only one is pending, that one is granted.
REQ-021 d_read and d_write both 1: write SHALL take precedence; pmem_write=1, pmem_read=0.
REQ-022 Requester dropping its request mid-grant SHALL NOT abort the memory transaction; the latched request completes and resp is still pulsed.
REQ-023 pmem_resp in IDLE SHALL be ignored; no resp is generated.

Reset
REQ-024 rst=0 at a clock edge: state IDLE; latched address/wdata 0; last_grant=D; outputs pmem_read=pmem_write=0, pmem_address=0, pmem_wdata=0, i_resp=d_resp=0, i_rdata=d_rdata=0.
REQ-025 Reset mid-transaction SHALL abandon the grant with no resp pulse; pmem_read/pmem_write SHALL be 0 from the cycle after the reset edge.
REQ-026 First grant after reset with both pending SHALL go to the dcache in both configurations.

Configuration
REQ-027 Macro CACHE_ARB_ROUND_ROBIN_EN defined: when both are pending, grant the requester not in last_grant; last_grant updates on each grant.
REQ-028 Macro undefined: fixed priority, dcache always wins ties; last_grant register is not implemented.

Structure
REQ-029 Shared package cache_arb_pkg SHALL hold the state enum (IDLE, GRANT_I, GRANT_D), the requester enum (REQ_I, REQ_D), and default ADDR_W/LINE_W constants.
REQ-030 Tie-break logic SHALL live in sub-module cache_arb_select (inputs: i_pending, d_pending, last_grant; output: selected requester); all other logic is in cache_arbiter.

Verification
REQ-031 Icache only: i_read=1, i_address=0x0000_1000; pmem_resp returns 3 cycles later with pmem_rdata=0xA5..A5 -> pmem_read=1 one cycle after the request; pmem_address=0x1000; i_resp=1 for 1 cycle with i_rdata=0xA5..A5.
REQ-032 Simultaneous requests: i_read=1 (0x100) and d_write=1 (0x200, d_wdata=0x5A..5A) -> dcache is granted first (pmem_write=1, pmem_wdata=0x5A..5A), then the icache after one IDLE cycle.
REQ-033 Round-robin (macro defined): both requesters issue 4 requests each, continuously, back-to-back -> grants alternate D,I,D,I,D,I,D,I. Macro undefined: all D grants complete first.
REQ-034 Reset mid-transaction: rst=0 while in GRANT_I, pmem_resp held 0 -> next cycle pmem_read=0 and state IDLE; a subsequent pmem_resp=1 produces no i_resp.
REQ-035 Request dropped mid-grant: d_read deasserted 1 cycle into GRANT_D -> pmem_read stays 1 until pmem_resp; d_resp still pulses.
